// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: arbitrates fetch and data ports onto the
// byte-wide bus, assembling little-endian words and pulsing done per access.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [1:0]  dm_type,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic        is_dm;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rbuf;

    logic [31:0] nxt_addr;
    logic [31:0] rd_word;
    logic        io_stall;
    logic [1:0]  cap_idx;
    logic [2:0]  dm_len;

    // In READ, cnt counts edges since accept: address cnt is issued and byte
    // cnt-2 is captured on the same edge, the last byte arriving at cnt = len+1.
    always_comb begin
        nxt_addr = base + {29'd0, cnt};
        io_stall = (nxt_addr[17:16] == 2'b11) && io_buffer_full;
        cap_idx  = cnt[1:0] - 2'd2;
        rd_word  = rbuf | ({24'd0, mem_din} << {len - 3'd1, 3'b000});
        case (dm_type)
            2'b00:   dm_len = 3'd1;
            2'b01:   dm_len = 3'd2;
            default: dm_len = 3'd4;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            cnt      <= '0;
            len      <= '0;
            is_dm    <= 1'b0;
            base     <= '0;
            wdata    <= '0;
            rbuf     <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
            if_done  <= 1'b0;
            dm_done  <= 1'b0;
            if_data  <= '0;
            dm_rdata <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (dm_req) begin
                        is_dm <= 1'b1;
                        base  <= dm_addr;
                        wdata <= dm_wdata;
                        len   <= dm_len;
                        rbuf  <= '0;
                        mem_a <= dm_addr;
                        if (dm_wr) begin
                            mem_dout <= dm_wdata[7:0];
                            state    <= WRITE;
                            if ((dm_addr[17:16] == 2'b11) && io_buffer_full) begin
                                mem_wr <= 1'b0;
                                cnt    <= 3'd0;
                            end else begin
                                mem_wr <= 1'b1;
                                cnt    <= 3'd1;
                            end
                        end else begin
                            state <= READ;
                            cnt   <= 3'd1;
                        end
                    end else if (if_req) begin
                        is_dm <= 1'b0;
                        base  <= if_addr;
                        len   <= 3'd4;
                        rbuf  <= '0;
                        mem_a <= if_addr;
                        state <= READ;
                        cnt   <= 3'd1;
                    end
                end
                READ: begin
                    if (cnt == len + 3'd1) begin
                        state <= DONE;
                        if (is_dm) begin
                            dm_rdata <= rd_word;
                            dm_done  <= 1'b1;
                        end else begin
                            if_data <= rd_word;
                            if_done <= 1'b1;
                        end
                    end else begin
                        if (cnt < len)
                            mem_a <= nxt_addr;
                        if (cnt >= 3'd2)
                            rbuf[{cap_idx, 3'b000} +: 8] <= mem_din;
                        cnt <= cnt + 3'd1;
                    end
                end
                WRITE: begin
                    if (cnt == len) begin
                        mem_wr  <= 1'b0;
                        dm_done <= 1'b1;
                        state   <= DONE;
                    end else begin
                        mem_a    <= nxt_addr;
                        mem_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
                        if (io_stall) begin
                            mem_wr <= 1'b0;
                        end else begin
                            mem_wr <= 1'b1;
                            cnt    <= cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the CPU pipeline and the external byte-wide memory/IO bus. It serves two requesters: the instruction-fetch port (pc_reg/if_id side) and the data port (mem stage). It serialises each 1-, 2- or 4-byte access into little-endian byte transfers and returns the assembled word with a one-cycle done pulse. Data accesses take priority over fetches, and UART back-pressure is honoured on IO writes.

## Interface
- No parameters.
- `clk_in` — in, 1 — system clock; all state updates on its rising edge.
- `rst_in` — in, 1 — asynchronous, active-low reset.
- `rdy_in` — in, 1 — when low, freeze all state and outputs.
- `if_req` — in, 1 — fetch request, level; held until `if_done`.
- `if_addr` — in, 32 — fetch address; always a 4-byte read.
- `if_data` — out, 32 — fetched word; valid while `if_done` = 1.
- `if_done` — out, 1 — one-cycle completion pulse for a fetch.
- `dm_req` — in, 1 — data request, level; held until `dm_done`.
- `dm_wr` — in, 1 — 1 = store, 0 = load.
- `dm_type` — in, 2 — access size: 00 byte, 01 half, 10 word, 11 treated as word.
- `dm_addr` — in, 32 — data address.
- `dm_wdata` — in, 32 — store data; low bytes are used.
- `dm_rdata` — out, 32 — load data, zero-extended; valid while `dm_done` = 1.
- `dm_done` — out, 1 — one-cycle completion pulse for a data access.
- `mem_din` — in, 8 — read byte; valid in the cycle after its address is driven.
- `mem_dout` — out, 8 — write byte.
- `mem_a` — out, 32 — byte address.
- `mem_wr` — out, 1 — 1 = write.
- `io_buffer_full` — in, 1 — UART transmit buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE. A byte counter `cnt` (0..4) and a length `N` (1, 2 or 4) are latched at accept.
- IDLE:
  - If `dm_req` = 1, accept the data port.
  - Else if `if_req` = 1, accept the fetch port.
  - Else stay in IDLE.
- Simultaneous requests: the data port wins; the fetch stays pending and is accepted in a later IDLE cycle.
- Accept:
  - Latch port, address, size and write data.
  - Drive `mem_a` with the base address.
  - For a write, also drive `mem_dout` with byte 0 and set `mem_wr` = 1.
  - Go to READ or WRITE.
- READ:
  - Drive `mem_a` = base + k for k = 0..N-1 on consecutive cycles.
  - Capture `mem_din` into byte k one cycle after address k.
  - After byte N-1 is captured, go to DONE.
- WRITE:
  - Drive base + k with byte k of `dm_wdata` and `mem_wr` = 1 for k = 0..N-1.
  - Then drop `mem_wr` and go to DONE.
- IO stall: a write byte with `mem_a[17:16]` = 2'b11 is not issued while `io_buffer_full` = 1. Hold `mem_wr` = 0 and the counter; resume the cycle after `io_buffer_full` falls.
- DONE:
  - Pulse the owning port's done signal for exactly one cycle, with the data output valid.
  - Accept no new request; return to IDLE at the next edge.
  - Requesters drop or change `req` in the DONE cycle.
- Address arithmetic: base + k is computed modulo 2^32 and wraps.
- Unused high bytes of `dm_rdata` are 0.
- `if_data` and `dm_rdata` hold their last value outside their done cycles.
- `rdy_in` = 0: state, counter, captured bytes and all outputs hold. No capture of `mem_din` takes place while frozen.

## Timing
- Reset values: state IDLE, `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0, `if_done` = 0, `dm_done` = 0, `if_data` = 0, `dm_rdata` = 0.
- Reset is asynchronous. An assertion mid-access aborts it immediately: no done pulse and no further `mem_wr`.
- Read of N bytes accepted at edge E0:
  - Addresses are driven after E0 through E(N-1).
  - Byte k is captured at E(k+2).
  - Done is high for the cycle after E(N+1).
  - Word read: done 6 cycles after acceptance. Byte read: done 3 cycles after acceptance.
- Write of N bytes accepted at E0:
  - Bytes are driven after E0 through E(N-1).
  - `mem_wr` falls at E(N).
  - Done is high for the cycle after E(N).
  - Each IO-stall cycle adds one cycle.
- Back-to-back: the next accept happens no earlier than the edge that ends the DONE cycle.

## Test plan
- Word fetch at 0x100, memory holding 13 05 00 00 at 0x100..0x103:
  - `mem_a` sequence 0x100..0x103.
  - `if_done` is a single pulse, 6 cycles after accept.
  - `if_data` = 0x00000513.
- `if_req` and `dm_req` (byte load at 0x2000, memory holding 0xFF) raised together:
  - The data access is served first, with `dm_rdata` = 0x000000FF.
  - The fetch is accepted after DONE and completes correctly.
- Half store of 0xDEADBEEF to 0x1002:
  - `mem_wr` = 1 for exactly two cycles: (0x1002, 0xEF) then (0x1003, 0xBE).
  - `dm_done` one cycle after the last byte.
- Byte store 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles:
  - `mem_wr` stays 0 for those 3 cycles, then one write of 0x41.
  - `dm_done` follows.
- Word load at 0x0FFFFFFFE with `rdy_in` low for 2 cycles mid-transfer:
  - Addresses wrap to 0x0 and 0x1.
  - Outputs are frozen during the stall.
  - `dm_rdata` is correct and done is delayed by exactly 2 cycles.
- `rst_in` pulsed low during the second byte of a word store:
  - All outputs return to reset values immediately.
  - No done pulse.
  - A fresh fetch after release completes normally.
